// File: rtl/sweep_sequencer_pkg.sv
// Shared types for the sweep sequencer: FSM state encoding, axis/direction codes, timer width.
package sweep_sequencer_pkg;

    localparam int unsigned TIMER_W = 26;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        H_HOME  = 4'd1,
        H_SWEEP = 4'd2,
        H_MAX   = 4'd3,
        V_HOME  = 4'd4,
        V_SWEEP = 4'd5,
        V_MAX   = 4'd6,
        HOLD    = 4'd7,
        MAN     = 4'd8
    } state_e;

    localparam logic AXIS_H  = 1'b0;
    localparam logic AXIS_V  = 1'b1;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    function automatic logic axis_of(input state_e s);
        return (s == V_HOME || s == V_SWEEP || s == V_MAX) ? AXIS_V : AXIS_H;
    endfunction

endpackage

// File: rtl/sweep_sequencer_phase_timer.sv
// Load/enable down-counter; expired is high while the count sits at 1 (last cycle of a phase).
module sweep_sequencer_phase_timer
    import sweep_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] load_val,
    output logic               expired
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == TIMER_W'(1));

endmodule

// File: rtl/sweep_sequencer.sv
// Tracking FSM: home, sweep and return-to-peak for each axis, horizontal first.
// Optional SOLAR_RETRACK_EN: HOLD re-enters H_HOME after RETRACK_CYCLES.
module sweep_sequencer
    import sweep_sequencer_pkg::*;
#(
    parameter int unsigned SWEEP_CYCLES   = 2_000_000,
    parameter int unsigned LIGHT_W        = 12,
    parameter int unsigned RETRACK_CYCLES = 50_000_000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               MAN_REQ,
    input  logic [LIGHT_W-1:0] LIGHT,
    input  logic               LIGHT_VLD,
    input  logic               CNT_RU,
    output logic               MC,
    output logic               CNT_RST,
    output logic               SERVO_EN,
    output logic               SERVO_SEL,
    output logic               SERVO_DIR,
    output logic               BUSY,
    output logic               DONE,
    output logic [LIGHT_W-1:0] MAX_H,
    output logic [LIGHT_W-1:0] MAX_V
);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic [LIGHT_W-1:0] peak_h_q, peak_h_d;
    logic [LIGHT_W-1:0] peak_v_q, peak_v_d;
    logic   mc_q, mc_d;
    logic   cnt_rst_q, cnt_rst_d;
    logic   en_q, en_d;
    logic   sel_q, sel_d;
    logic   dir_q, dir_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;

    logic               entering;
    logic               new_peak;
    logic               timer_en;
    logic               timer_expired;
    logic [TIMER_W-1:0] timer_val;

    assign entering = (state_d != state_q);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            first_q   <= 1'b1;
            peak_h_q  <= '0;
            peak_v_q  <= '0;
            mc_q      <= 1'b0;
            cnt_rst_q <= 1'b1;
            en_q      <= 1'b0;
            sel_q     <= AXIS_H;
            dir_q     <= DIR_FWD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            peak_h_q  <= peak_h_d;
            peak_v_q  <= peak_v_d;
            mc_q      <= mc_d;
            cnt_rst_q <= cnt_rst_d;
            en_q      <= en_d;
            sel_q     <= sel_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (START) state_d = H_HOME;
            H_HOME:  if (timer_expired) state_d = H_SWEEP;
            H_SWEEP: if (timer_expired) state_d = H_MAX;
            H_MAX:   if (!first_q && !CNT_RU) state_d = V_HOME;
            V_HOME:  if (timer_expired) state_d = V_SWEEP;
            V_SWEEP: if (timer_expired) state_d = V_MAX;
            V_MAX:   if (!first_q && !CNT_RU) state_d = HOLD;
`ifdef SOLAR_RETRACK_EN
            HOLD:    if (START || timer_expired) state_d = H_HOME;
`else
            HOLD:    if (START) state_d = H_HOME;
`endif
            MAN:     if (!MAN_REQ) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (MAN_REQ) begin
            state_d = MAN;
        end
        first_d = entering;
    end

    // A sample on the last sweep cycle still counts; its CNT_RST lands on the MAX settle cycle.
    always_comb begin
        new_peak = 1'b0;
        peak_h_d = peak_h_q;
        peak_v_d = peak_v_q;
        if (state_q == H_SWEEP && LIGHT_VLD && LIGHT > peak_h_q) begin
            new_peak = 1'b1;
            peak_h_d = LIGHT;
        end
        if (state_q == V_SWEEP && LIGHT_VLD && LIGHT > peak_v_q) begin
            new_peak = 1'b1;
            peak_v_d = LIGHT;
        end
        if (state_d == H_SWEEP && entering) peak_h_d = '0;
        if (state_d == V_SWEEP && entering) peak_v_d = '0;
    end

    always_comb begin
        mc_d      = 1'b0;
        cnt_rst_d = 1'b1;
        en_d      = 1'b0;
        sel_d     = AXIS_H;
        dir_d     = DIR_FWD;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        unique case (state_d)
            H_HOME, V_HOME: begin
                en_d  = 1'b1;
                sel_d = axis_of(state_d);
                dir_d = DIR_REV;
            end
            H_SWEEP, V_SWEEP: begin
                en_d      = 1'b1;
                sel_d     = axis_of(state_d);
                cnt_rst_d = entering || new_peak;
            end
            H_MAX, V_MAX: begin
                mc_d      = 1'b1;
                en_d      = 1'b1;
                sel_d     = axis_of(state_d);
                dir_d     = DIR_REV;
                cnt_rst_d = new_peak;
            end
            HOLD: begin
                busy_d = 1'b0;
                done_d = entering;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_comb begin
        unique case (state_d)
            H_HOME, H_SWEEP, V_HOME, V_SWEEP: timer_val = TIMER_W'(SWEEP_CYCLES);
            HOLD:                             timer_val = TIMER_W'(RETRACK_CYCLES);
            default:                          timer_val = '0;
        endcase
`ifdef SOLAR_RETRACK_EN
        timer_en = (state_q == H_HOME) || (state_q == H_SWEEP) || (state_q == V_HOME) ||
                   (state_q == V_SWEEP) || (state_q == HOLD);
`else
        timer_en = (state_q == H_HOME) || (state_q == H_SWEEP) || (state_q == V_HOME) ||
                   (state_q == V_SWEEP);
`endif
    end

    sweep_sequencer_phase_timer u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (entering),
        .en       (timer_en),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    assign MC        = mc_q;
    assign CNT_RST   = cnt_rst_q;
    assign SERVO_EN  = en_q;
    assign SERVO_SEL = sel_q;
    assign SERVO_DIR = dir_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign MAX_H     = peak_h_q;
    assign MAX_V     = peak_v_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer with a behavioural max counter; peak pulses are scoreboarded.
module tb_sweep_sequencer;
    import sweep_sequencer_pkg::*;

    localparam int SW = 16;
    localparam int LW = 12;
    localparam int RT = 32;

    logic          CLK = 1'b0;
    logic          RST_N, START, MAN_REQ, LIGHT_VLD, CNT_RU;
    logic [LW-1:0] LIGHT;
    logic          MC, CNT_RST, SERVO_EN, SERVO_SEL, SERVO_DIR, BUSY, DONE;
    logic [LW-1:0] MAX_H, MAX_V;

    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    int   pat_c[4];
    int   pat_v[4];
    logic [7:0] mcnt = '0;

    sweep_sequencer #(
        .SWEEP_CYCLES   (SW),
        .LIGHT_W        (LW),
        .RETRACK_CYCLES (RT)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .START     (START),
        .MAN_REQ   (MAN_REQ),
        .LIGHT     (LIGHT),
        .LIGHT_VLD (LIGHT_VLD),
        .CNT_RU    (CNT_RU),
        .MC        (MC),
        .CNT_RST   (CNT_RST),
        .SERVO_EN  (SERVO_EN),
        .SERVO_SEL (SERVO_SEL),
        .SERVO_DIR (SERVO_DIR),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .MAX_H     (MAX_H),
        .MAX_V     (MAX_V)
    );

    always #5 CLK = ~CLK;

    // Max counter: counts sweep cycles since the last peak, then counts them back.
    always @(posedge CLK) begin
        if (!RST_N || CNT_RST) mcnt <= '0;
        else if (!MC)          mcnt <= mcnt + 8'd1;
        else if (mcnt != '0)   mcnt <= mcnt - 8'd1;
    end
    assign CNT_RU = (mcnt != '0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [6:0] outs();
        return {MC, CNT_RST, SERVO_EN, SERVO_SEL, SERVO_DIR, BUSY, DONE};
    endfunction

    task automatic pulse_seen(input int k);
        if (exp_q.size() == 0) chk("pulse_spurious", k, 0);
        else                   chk("pulse_at", k, exp_q.pop_front());
    endtask

    task automatic do_home(input logic axis);
        int w = 0;
        int n = 0;
        while (!(SERVO_EN && SERVO_DIR && !MC && BUSY) && w < 100) begin
            w++;
            tick;
        end
        chk("home_found", 32'(w < 100), 1);
        chk("home_out", {SERVO_SEL, CNT_RST}, {axis, 1'b1});
        while (SERVO_EN && SERVO_DIR && !MC && BUSY && n < 100) begin
            n++;
            tick;
        end
        chk("home_len", n, SW);
    endtask

    task automatic run_sweep(input logic axis);
        int   model_peak = 0;
        int   last_peak  = 0;
        int   exp_len;
        int   n = 0;
        logic ok_run = 1'b1;
        chk("sweep_entry", {SERVO_EN, SERVO_DIR, MC, CNT_RST}, 4'b1001);
        chk("sweep_clr", axis ? MAX_V : MAX_H, 0);
        for (int k = 1; k <= SW; k++) begin
            if (k > 1 && CNT_RST) pulse_seen(k);
            if (!SERVO_EN || SERVO_DIR || MC || SERVO_SEL != axis) ok_run = 1'b0;
            LIGHT_VLD = 1'b0;
            LIGHT     = '0;
            for (int j = 0; j < 4; j++) begin
                if (pat_c[j] == k) begin
                    LIGHT_VLD = 1'b1;
                    LIGHT     = LW'(pat_v[j]);
                    if (pat_v[j] > model_peak) begin
                        model_peak = pat_v[j];
                        last_peak  = k;
                        exp_q.push_back(k + 1);
                    end
                end
            end
            tick;
        end
        LIGHT_VLD = 1'b0;
        if (CNT_RST) pulse_seen(SW + 1);
        chk("pulse_missing", exp_q.size(), 0);
        exp_q.delete();
        chk("sweep_run", ok_run, 1);
        chk("peak", axis ? MAX_V : MAX_H, model_peak);
        exp_len = (last_peak >= SW - 1) ? 2 : SW - last_peak;
        ok_run  = 1'b1;
        while (MC && n < 100) begin
            if (!SERVO_EN || !SERVO_DIR || SERVO_SEL != axis) ok_run = 1'b0;
            n++;
            tick;
        end
        chk("max_len", n, exp_len);
        chk("max_run", ok_run, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        int dn;
        RST_N = 1'b0; START = 1'b0; MAN_REQ = 1'b0; LIGHT_VLD = 1'b0; LIGHT = '0;
        repeat (3) tick;
        chk("rst_outs", outs(), 7'b0100000);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        RST_N = 1'b1;
        tick;

        // reset in the middle of a horizontal sweep
        START = 1'b1; tick; START = 1'b0;
        do_home(AXIS_H);
        LIGHT_VLD = 1'b1; LIGHT = 12'd100; tick; LIGHT_VLD = 1'b0; tick;
        chk("pre_rst_peak", MAX_H, 100);
        RST_N = 1'b0; tick;
        chk("midrst_outs", outs(), 7'b0100000);
        chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("midrst_maxh", MAX_H, 0);
        RST_N = 1'b1; tick;

        // full track: ramp on H, equal peaks on V
        START = 1'b1; tick; START = 1'b0;
        do_home(AXIS_H);
        pat_c = '{2, 5, 9, 12};  pat_v = '{10, 40, 90, 30};
        run_sweep(AXIS_H);
        do_home(AXIS_V);
        pat_c = '{3, 8, 0, 0};   pat_v = '{50, 50, 0, 0};
        run_sweep(AXIS_V);
        chk("done_entry", outs(), 7'b0100001);
        n = 0; dn = 0;
        while (!BUSY && n < 1000) begin
            if (DONE) dn++;
            n++;
            tick;
        end
`ifdef SOLAR_RETRACK_EN
        chk("retrack_len", n, RT);
`else
        chk("hold_len", n, 1000);
`endif
        chk("done_cnt", dn, 1);
        chk("hold_maxh", MAX_H, 90);
        chk("hold_maxv", MAX_V, 50);
`ifndef SOLAR_RETRACK_EN
        START = 1'b1; tick; START = 1'b0;
`endif

        // peak on the final sweep cycle
        do_home(AXIS_H);
        pat_c = '{4, 16, 0, 0};  pat_v = '{20, 70, 0, 0};
        run_sweep(AXIS_H);

        // manual override during V sweep, then START/MAN_REQ collision
        do_home(AXIS_V);
        repeat (4) tick;
        MAN_REQ = 1'b1; tick;
        chk("man_outs", outs(), 7'b0100000);
        chk("man_state", 32'(dut.state_q), 32'(MAN));
        repeat (2) tick;
        chk("man_stay", 32'(dut.state_q), 32'(MAN));
        MAN_REQ = 1'b0; tick;
        chk("man_rel", 32'(dut.state_q), 32'(IDLE));
        MAN_REQ = 1'b1; START = 1'b1; tick; START = 1'b0;
        chk("collide_state", 32'(dut.state_q), 32'(MAN));
        chk("collide_busy", BUSY, 0);
        MAN_REQ = 1'b0; tick;
        chk("collide_rel", 32'(dut.state_q), 32'(IDLE));
        tick;
        chk("idle_quiet", outs(), 7'b0100000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
